// File: rtl/ram_line_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_line_adapter_pkg
// Description : Shared types and helpers for the 32-bit word to 128-bit line
//               RAM adapter: FSM state encoding, line geometry constants and
//               the word-lane bit offset function.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_line_adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_WIDTH     = 32;
    localparam int LINE_WIDTH     = WORDS_PER_LINE * WORD_WIDTH;

    // Big-endian word placement: word 0 sits in the top 32 bits of the line.
    function automatic int word_offset(input logic [1:0] idx);
        return (WORDS_PER_LINE - 1 - int'(idx)) * WORD_WIDTH;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_line_adapter_line_merge.sv
`default_nettype none
// ============================================================================
// Module      : ram_line_adapter_line_merge
// Description : Combinational line merge. Extracts the addressed 32-bit word
//               from a 128-bit line and produces the line with the enabled
//               bytes of that word replaced by new write data.
// Ports       : old_line    - line as read from the RAM
//               word_idx    - word within the line (0 = bits [127:96])
//               byte_en     - byte enables, bit i covers wdata[8i+7:8i]
//               wdata       - new write data
//               merged_line - old_line with the enabled bytes replaced
//               old_word    - addressed word of old_line
// Revision    : 1.0 - initial release
// ============================================================================
module ram_line_adapter_line_merge
    import ram_line_adapter_pkg::*;
(
    input  logic [LINE_WIDTH-1:0] old_line,
    input  logic [1:0]            word_idx,
    input  logic [3:0]            byte_en,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [LINE_WIDTH-1:0] merged_line,
    output logic [WORD_WIDTH-1:0] old_word
);

    always_comb begin
        merged_line = old_line;
        old_word    = old_line[word_offset(word_idx) +: WORD_WIDTH];
        for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) begin
                merged_line[word_offset(word_idx) + 8*b +: 8] = wdata[8*b +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : ram_line_adapter
// Description : Bridges a 32-bit word-addressed, byte-enabled request/ready
//               bus to one port of a 128-bit, 1-cycle-latency, write-first
//               block RAM. Every write is a read-modify-write of the line.
//               One transaction every 3 cycles (IDLE -> ACCESS -> DONE).
// Ports       : clk, rst (synchronous, active-low)
//               req_addr/req_read/req_we/req_wdata - request from requester
//               req_rdata/req_ready                - completion to requester
//               ram_addr/ram_we/ram_din/ram_dout   - RAM port
// Revision    : 1.0 - initial release
// ============================================================================
module ram_line_adapter
    import ram_line_adapter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic                  req_read,
    input  logic [3:0]            req_we,
    input  logic [31:0]           req_wdata,
    output logic [31:0]           req_rdata,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [127:0]          ram_din,
    input  logic [127:0]          ram_dout
);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_line;
    logic [1:0]              r_word;
    logic [3:0]              r_be;
    logic [31:0]             r_wdata;
    logic                    r_is_write;
    logic [31:0]             r_rdata;
    logic                    r_ready;

    logic                    w_req_valid;
    logic [LINE_WIDTH-1:0]   w_merged;
    logic [WORD_WIDTH-1:0]   w_old_word;

    assign w_req_valid = req_read | (|req_we);

    // In IDLE the request address goes straight to the RAM so the old line
    // is already on ram_dout during ACCESS.
    assign ram_addr = (r_state == ST_IDLE) ? req_addr[ADDR_WIDTH+1:2] : r_line;

    // Gated by rst so a reset landing in ACCESS aborts the write.
    assign ram_we  = rst & (r_state == ST_ACCESS) & r_is_write;
    assign ram_din = w_merged;

    assign req_rdata = r_rdata;
    assign req_ready = r_ready;

    ram_line_adapter_line_merge u_line_merge (
        .old_line    (ram_dout),
        .word_idx    (r_word),
        .byte_en     (r_be),
        .wdata       (r_wdata),
        .merged_line (w_merged),
        .old_word    (w_old_word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_line     <= '0;
            r_word     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (w_req_valid) begin
                        r_line     <= req_addr[ADDR_WIDTH+1:2];
                        r_word     <= req_addr[1:0];
                        r_be       <= req_we;
                        r_wdata    <= req_wdata;
                        // A write wins over a simultaneous read; the read
                        // data still returns the pre-write word.
                        r_is_write <= |req_we;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= w_old_word;
                    r_ready <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_line_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_line_adapter
// Description : Self-checking bench for ram_line_adapter with a behavioural
//               write-first RAM, a word-level reference memory and a
//               scoreboard monitor for read data and RAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_line_adapter;

    localparam int AW = 6;
    localparam int NL = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW+1:0] req_addr;
    logic          req_read;
    logic [3:0]    req_we;
    logic [31:0]   req_wdata;
    logic [31:0]   req_rdata;
    logic          req_ready;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [127:0]  ram_din;
    logic [127:0]  ram_dout;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [127:0]  pre_din;

    always #5 clk = ~clk;

    ram_line_adapter #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_addr  (req_addr),
        .req_read  (req_read),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .req_ready (req_ready),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural write-first block RAM with a preload port.
    logic [127:0] mem [NL];
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_din;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= ram_we ? ram_din : mem[ram_addr];
    end

    // Reference model: memory viewed as individually addressed words.
    logic [31:0]   ref_w [4*NL];
    logic [31:0]   exp_rd_q [$];
    logic [AW-1:0] exp_wa_q [$];
    logic [127:0]  exp_wd_q [$];

    int n_checks = 0;
    int n_pass   = 0;
    bit fresh    = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] ref_line(input int l);
        return {ref_w[4*l], ref_w[4*l+1], ref_w[4*l+2], ref_w[4*l+3]};
    endfunction

    // Monitor: compares every RAM write and every completion against the
    // expectations queued by the stimulus side.
    always @(negedge clk) begin
        if (ram_we) begin
            if (exp_wd_q.size() == 0) begin
                chk("ram_we_unexpected", 128'(ram_we), 128'(0));
            end else begin
                chk("ram_addr", 128'(ram_addr), 128'(exp_wa_q.pop_front()));
                chk("ram_din", ram_din, exp_wd_q.pop_front());
            end
        end
        if (req_ready) begin
            if (exp_rd_q.size() == 0) begin
                chk("req_ready_unexpected", 128'(req_ready), 128'(0));
            end else begin
                chk("req_rdata", 128'(req_rdata), 128'(exp_rd_q.pop_front()));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        fresh = 1'b1;
    endtask

    task automatic do_req(input logic [AW+1:0] a, input logic rd,
                          input logic [3:0] we, input logic [31:0] wd);
        int            n;
        int            exp_lat;
        logic [31:0]   w;
        logic [AW-1:0] l;
        // From IDLE the answer comes after 2 edges; issued while the
        // previous transaction is in DONE it takes one more.
        exp_lat = fresh ? 2 : 3;
        fresh   = 1'b0;
        req_addr  = a;
        req_read  = rd;
        req_we    = we;
        req_wdata = wd;
        exp_rd_q.push_back(ref_w[a]);
        if (we != 4'h0) begin
            w = ref_w[a];
            for (int b = 0; b < 4; b++) begin
                if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
            end
            ref_w[a] = w;
            l = a[AW+1:2];
            exp_wa_q.push_back(l);
            exp_wd_q.push_back(ref_line(int'(l)));
        end
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 8);
        chk("latency", 128'(n), 128'(exp_lat));
        req_read = 1'b0;
        req_we   = 4'h0;
    endtask

    initial begin
        req_addr  = '0;
        req_read  = 1'b0;
        req_we    = 4'h0;
        req_wdata = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_din   = '0;
        rst       = 1'b0;

        // Preload RAM and reference while the adapter is held in reset.
        for (int l = 0; l < NL; l++) begin
            for (int w = 0; w < 4; w++) ref_w[4*l+w] = $urandom;
            if (l == 5) begin
                ref_w[20] = 32'h00112233;
                ref_w[21] = 32'h44556677;
                ref_w[22] = 32'h8899AABB;
                ref_w[23] = 32'hCCDDEEFF;
            end
            pre_we   = 1'b1;
            pre_addr = AW'(l);
            pre_din  = ref_line(l);
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_ready", 128'(req_ready), 128'(0));
        chk("reset_rdata", 128'(req_rdata), 128'(0));
        rst = 1'b1;
        idle(1);

        // Directed cases.
        do_req(8'h16, 1'b1, 4'h0, 32'h0);
        idle(1);
        do_req(8'h15, 1'b0, 4'b0101, 32'hDEADBEEF);
        do_req(8'h15, 1'b1, 4'h0, 32'h0);
        idle(1);
        do_req(8'h14, 1'b1, 4'hF, 32'h12345678);
        do_req(8'h14, 1'b1, 4'h0, 32'h0);
        idle(1);

        // Reset in the ACCESS cycle of a write aborts it.
        req_addr  = 8'h16;
        req_read  = 1'b0;
        req_we    = 4'hF;
        req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", 128'(req_ready), 128'(0));
        chk("abort_rdata", 128'(req_rdata), 128'(0));
        rst    = 1'b1;
        req_we = 4'h0;
        idle(1);
        do_req(8'h16, 1'b1, 4'h0, 32'h0);
        idle(1);

        // Back-to-back writes to every word of line 7, then read them back.
        for (int w = 0; w < 4; w++) do_req({6'd7, 2'(w)}, 1'b0, 4'hF, $urandom);
        for (int w = 0; w < 4; w++) do_req({6'd7, 2'(w)}, 1'b1, 4'h0, 32'h0);
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_req(8'($urandom_range(0, 255)), 1'b1, 4'h0, $urandom);
            end else begin
                do_req(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                       4'($urandom_range(1, 15)), $urandom);
            end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(3);
        chk("rd_queue_drained", 128'(exp_rd_q.size()), 128'(0));
        chk("wr_queue_drained", 128'(exp_wd_q.size()), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
